// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run controller: core reset sequencing, free/single-step run, checkpoint scoring, watchdog
module core_run_ctrl #(
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_insn_vld,
    input  logic             i_ledr_we,
    input  logic [31:0]      i_ledr_wdata,
    input  logic [31:0]      i_end_pc,
    output logic             o_core_reset,
    output logic             o_core_en,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic [CNT_W-1:0] o_illegal_cnt,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_all_pass
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CORE_RST  = 3'd1,
        S_RUN       = 3'd2,
        S_STEP_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [RC_W-1:0]   rst_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              single_step;

    logic              en;
    logic              end_hit;
    logic              wd_hit;
    logic [CNT_W-1:0]  pass_nx;
    logic [CNT_W-1:0]  fail_nx;
    logic [CNT_W-1:0]  ill_nx;
    logic              all_pass_nx;

    assign o_state = state;

    // Core inputs only matter while the core is actually clocked (RUN).
    always_comb begin
        en      = (state == S_RUN);
        end_hit = en && i_insn_vld && (i_pc_debug == i_end_pc);
        wd_hit  = en && (wd_cnt == WD_LAST);
        pass_nx = o_pass_cnt;
        fail_nx = o_fail_cnt;
        ill_nx  = o_illegal_cnt;
        if (en && i_ledr_we && (i_ledr_wdata == 32'h1) && (o_pass_cnt != CNT_MAX))
            pass_nx = o_pass_cnt + 1'b1;
        if (en && i_ledr_we && (i_ledr_wdata != 32'h1) && (o_fail_cnt != CNT_MAX))
            fail_nx = o_fail_cnt + 1'b1;
        if (en && !i_insn_vld && (o_illegal_cnt != CNT_MAX))
            ill_nx = o_illegal_cnt + 1'b1;
        all_pass_nx = end_hit && (fail_nx == '0) && (pass_nx != '0) && (ill_nx == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            o_core_reset  <= 1'b1;
            o_core_en     <= 1'b0;
            rst_cnt       <= '0;
            wd_cnt        <= '0;
            single_step   <= 1'b0;
            o_pass_cnt    <= '0;
            o_fail_cnt    <= '0;
            o_illegal_cnt <= '0;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
            o_all_pass    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state         <= S_CORE_RST;
                        o_core_reset  <= 1'b1;
                        o_core_en     <= 1'b0;
                        rst_cnt       <= '0;
                        wd_cnt        <= '0;
                        single_step   <= 1'b0;
                        o_pass_cnt    <= '0;
                        o_fail_cnt    <= '0;
                        o_illegal_cnt <= '0;
                        o_done        <= 1'b0;
                        o_timeout     <= 1'b0;
                        o_all_pass    <= 1'b0;
                    end
                end
                S_CORE_RST: begin
                    if (rst_cnt == RC_LAST) begin
                        o_core_reset <= 1'b0;
                        if (i_step_mode) begin
                            state <= S_STEP_WAIT;
                        end else begin
                            state     <= S_RUN;
                            o_core_en <= 1'b1;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_STEP_WAIT: begin
                    if (i_step) begin
                        state       <= S_RUN;
                        o_core_en   <= 1'b1;
                        single_step <= 1'b1;
                    end
                end
                S_RUN: begin
                    o_pass_cnt    <= pass_nx;
                    o_fail_cnt    <= fail_nx;
                    o_illegal_cnt <= ill_nx;
                    wd_cnt        <= wd_cnt + 1'b1;
                    single_step   <= 1'b0;
                    // End detection outranks the watchdog when both land together.
                    if (end_hit || wd_hit) begin
                        state      <= S_DONE;
                        o_core_en  <= 1'b0;
                        o_done     <= 1'b1;
                        o_timeout  <= !end_hit;
                        o_all_pass <= all_pass_nx;
                    end else if (single_step && i_step_mode) begin
                        state     <= S_STEP_WAIT;
                        o_core_en <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_core_reset <= 1'b1;
                    o_core_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl
module tb_core_run_ctrl;

    localparam int RST_CYCLES  = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;
    localparam logic [31:0] END_PC = 32'h0000_0abc;

    logic             i_clk = 1'b0;
    logic             i_reset, i_start, i_step_mode, i_step;
    logic [31:0]      i_pc_debug, i_ledr_wdata;
    logic             i_insn_vld, i_ledr_we;
    logic             o_core_reset, o_core_en, o_done, o_timeout, o_all_pass;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_pass_cnt, o_fail_cnt, o_illegal_cnt;

    core_run_ctrl #(.RST_CYCLES(RST_CYCLES), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
        .i_step(i_step), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
        .i_ledr_we(i_ledr_we), .i_ledr_wdata(i_ledr_wdata), .i_end_pc(END_PC),
        .o_core_reset(o_core_reset), .o_core_en(o_core_en), .o_state(o_state),
        .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt), .o_illegal_cnt(o_illegal_cnt),
        .o_done(o_done), .o_timeout(o_timeout), .o_all_pass(o_all_pass)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // in = {rst, start, step_mode, step, insn_vld, ledr_we, wdata_is_1, pc_is_end}
    typedef struct {
        logic [7:0] in;
        int st, cr, ce, p, f, il, dn, to, ap;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(input logic [7:0] in, input int st, input int cr, input int ce,
                               input int p, input int f, input int il,
                               input int dn, input int to, input int ap);
        vec_t r;
        r.in = in; r.st = st; r.cr = cr; r.ce = ce; r.p = p; r.f = f; r.il = il;
        r.dn = dn; r.to = to; r.ap = ap;
        return r;
    endfunction

    function automatic int outs();
        return int'({o_state, o_core_reset, o_core_en, o_pass_cnt, o_fail_cnt, o_illegal_cnt,
                     o_done, o_timeout, o_all_pass});
    endfunction

    function automatic int exp_outs(input vec_t r);
        return int'({3'(r.st), 1'(r.cr), 1'(r.ce), CNT_W'(r.p), CNT_W'(r.f), CNT_W'(r.il),
                     1'(r.dn), 1'(r.to), 1'(r.ap)});
    endfunction

    task automatic drive(input logic [7:0] in);
        {i_reset, i_start, i_step_mode, i_step, i_insn_vld, i_ledr_we} = in[7:2];
        i_ledr_wdata = in[1] ? 32'h1 : 32'h2;
        i_pc_debug   = in[0] ? END_PC : END_PC + 32'h4;
    endtask

    task automatic junk();
        i_insn_vld   = 1'($urandom_range(0, 1));
        i_ledr_we    = 1'($urandom_range(0, 1));
        i_ledr_wdata = ($urandom_range(0, 1) == 1) ? 32'h1 : 32'($urandom);
        i_pc_debug   = ($urandom_range(0, 1) == 1) ? END_PC : 32'($urandom);
    endtask

    task automatic wait_for_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (o_state != s && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check(name, int'(o_state), int'(s));
    endtask

    task automatic single_step_test();
        int en_cycles = 0;
        junk();
        i_step = 1'b0; i_step_mode = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_for_state(3'd3, 20, "ss_enter");
        for (int s = 0; s < 5; s++) begin
            for (int w = 0; w < 2; w++) begin
                i_insn_vld = 1'b0; i_ledr_we = 1'b1; i_ledr_wdata = 32'h0; i_pc_debug = END_PC;
                @(negedge i_clk);
                check("ss_wait", int'({o_state, o_core_en}), int'({3'd3, 1'b0}));
            end
            i_step = 1'b1;
            @(negedge i_clk);
            i_step = 1'b0;
            check("ss_run", int'({o_state, o_core_en}), int'({3'd2, 1'b1}));
            if (o_core_en) en_cycles++;
            i_insn_vld = 1'b1; i_ledr_we = 1'b1; i_ledr_wdata = 32'h1; i_pc_debug = END_PC + 32'h4;
            @(negedge i_clk);
            check("ss_back", int'({o_state, o_core_en}), int'({3'd3, 1'b0}));
        end
        check("ss_en_cycles", en_cycles, 5);
        check("ss_counts", int'({o_pass_cnt, o_fail_cnt, o_illegal_cnt}),
              int'({CNT_W'(CMAX), CNT_W'(0), CNT_W'(0)}));
        i_step_mode = 1'b0; i_step = 1'b1;
        @(negedge i_clk);
        i_step = 1'b0; i_insn_vld = 1'b1; i_ledr_we = 1'b0; i_pc_debug = END_PC + 32'h4;
        @(negedge i_clk);
        check("ss_free_resume", int'({o_state, o_core_en}), int'({3'd2, 1'b1}));
        i_pc_debug = END_PC;
        @(negedge i_clk);
        check("ss_done", int'({o_state, o_done, o_timeout, o_all_pass}), int'({3'd4, 3'b101}));
    endtask

    task automatic watchdog_test(input bit hit_end);
        int en_seen = 0;
        int n = 0;
        junk();
        i_step = 1'b0; i_step_mode = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (!o_done && n < 60) begin
            if (o_core_en) begin
                en_seen++;
                i_insn_vld   = 1'b1;
                i_ledr_we    = (en_seen == 1);
                i_ledr_wdata = 32'h1;
                i_pc_debug   = (hit_end && en_seen == TIMEOUT_CYC) ? END_PC : END_PC + 32'h4;
            end else begin
                junk();
            end
            @(negedge i_clk);
            n++;
        end
        check(hit_end ? "wd_hit_en_cycles" : "wd_en_cycles", en_seen, TIMEOUT_CYC);
        check(hit_end ? "wd_hit_result" : "wd_result",
              int'({o_state, o_done, o_timeout, o_all_pass}),
              int'({3'd4, 1'b1, !hit_end, hit_end}));
    endtask

    task automatic random_run();
        logic ev_we[16], ev_pass[16], ev_vld[16], ev_end[16];
        int n_exp, p_exp, f_exp, il_exp, ap_exp;
        bit end_found, clean;
        logic smode;
        logic prev_en = 1'b0;
        int k = 0, rst_seen = 0, consec = 0, cyc = 0;
        clean = ($urandom_range(0, 1) == 1);
        smode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            ev_we[i]   = ($urandom_range(0, 2) == 0);
            ev_pass[i] = clean || ($urandom_range(0, 3) != 0);
            ev_vld[i]  = clean || ($urandom_range(0, 7) != 0);
            ev_end[i]  = ($urandom_range(0, 7) == 0);
        end
        // Reference: the run lasts until the first legal end-PC retire, else TIMEOUT_CYC enabled cycles.
        n_exp = TIMEOUT_CYC;
        end_found = 0;
        for (int i = 0; i < TIMEOUT_CYC; i++)
            if (!end_found && ev_end[i] && ev_vld[i]) begin
                end_found = 1;
                n_exp = i + 1;
            end
        p_exp = 0; f_exp = 0; il_exp = 0;
        for (int i = 0; i < n_exp; i++) begin
            if (ev_we[i] && ev_pass[i]) p_exp++;
            if (ev_we[i] && !ev_pass[i]) f_exp++;
            if (!ev_vld[i]) il_exp++;
        end
        p_exp  = (p_exp > CMAX) ? CMAX : p_exp;
        f_exp  = (f_exp > CMAX) ? CMAX : f_exp;
        il_exp = (il_exp > CMAX) ? CMAX : il_exp;
        ap_exp = (end_found && f_exp == 0 && p_exp > 0 && il_exp == 0) ? 1 : 0;

        junk();
        i_step = 1'b0; i_step_mode = smode; i_start = 1'b1;
        @(negedge i_clk);
        while (!o_done && cyc < 400) begin
            if (o_core_reset && o_state == 3'd1) rst_seen++;
            if (o_core_en) begin
                if (prev_en && smode) consec++;
                if (k < 16) begin
                    i_insn_vld   = ev_vld[k];
                    i_ledr_we    = ev_we[k];
                    i_ledr_wdata = ev_pass[k] ? 32'h1 : (32'($urandom) & 32'hFFFF_FFFE);
                    i_pc_debug   = ev_end[k] ? END_PC : END_PC + 32'($urandom_range(1, 1000));
                end
                k++;
            end else begin
                junk();
            end
            prev_en = o_core_en;
            i_start = ($urandom_range(0, 9) == 0);
            i_step  = (o_state == 3'd3) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            @(negedge i_clk);
            cyc++;
        end
        i_start = 1'b0;
        i_step  = 1'b0;
        check("rnd_done", int'({o_state, o_done, o_core_en, o_core_reset}), int'({3'd4, 3'b100}));
        check("rnd_en_cycles", k, n_exp);
        check("rnd_rst_cycles", rst_seen, RST_CYCLES);
        check("rnd_step_len", consec, 0);
        check("rnd_pass", int'(o_pass_cnt), p_exp);
        check("rnd_fail", int'(o_fail_cnt), f_exp);
        check("rnd_illegal", int'(o_illegal_cnt), il_exp);
        check("rnd_timeout", int'(o_timeout), end_found ? 0 : 1);
        check("rnd_all_pass", int'(o_all_pass), ap_exp);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
        i_insn_vld = 1'b0; i_ledr_we = 1'b0; i_ledr_wdata = 32'h0; i_pc_debug = 32'h0;

        // free run: three passing writes then end PC
        vecs.push_back(v(8'b1000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0101, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0100_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(8'b0000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1110, 2, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1000, 2, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0100_1110, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1110, 2, 0, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1001, 4, 0, 0, 3, 0, 0, 1, 0, 1));
        vecs.push_back(v(8'b0000_0100, 4, 0, 0, 3, 0, 0, 1, 0, 1));
        // mixed results, last checkpoint coincides with end
        vecs.push_back(v(8'b0100_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(8'b0000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1110, 2, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1100, 2, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1111, 4, 0, 0, 2, 1, 0, 1, 0, 0));
        // reset mid-run, then clean restart
        vecs.push_back(v(8'b0100_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(8'b0000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0100, 2, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(v(8'b1000_0101, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0100_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(8'b0000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_1111, 4, 0, 0, 1, 0, 0, 1, 0, 1));
        // saturation and illegal cycles
        vecs.push_back(v(8'b0100_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(8'b0000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(8'b0000_1100, 2, 0, 1, 0, (i < 3) ? i + 1 : 3, 0, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 3, 1, 0, 0, 0));
        vecs.push_back(v(8'b0000_0000, 2, 0, 1, 0, 3, 2, 0, 0, 0));
        vecs.push_back(v(8'b0000_1111, 4, 0, 0, 1, 3, 2, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            @(negedge i_clk);
            check($sformatf("vec%0d", i), outs(), exp_outs(vecs[i]));
        end
        i_reset = 1'b0;

        single_step_test();
        watchdog_test(1'b0);
        watchdog_test(1'b1);

        for (int r = 0; r < 40; r++) begin
            if (r % 10 == 9) begin
                junk();
                i_reset = 1'b1; i_start = 1'b1;
                @(negedge i_clk);
                i_reset = 1'b0; i_start = 1'b0;
                check("rnd_reset", outs(), int'({3'd0, 1'b1, 1'b0, {(3 * CNT_W + 3){1'b0}}}));
            end
            random_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
